// File: rtl/msrh_icache_assoc.sv
// N-way set-associative VIPT instruction cache: S0 index, S1 tag compare, S2 way-select, one-line L2 refill.
// Define MSRH_ICACHE_INVALIDATE_EN to add the whole-cache invalidate sweep (i_inv_valid / o_inv_done).
module msrh_icache_assoc #(
    parameter int                   WAYS      = 4,
    parameter int                   SETS      = 64,
    parameter int                   LINE_W    = 128,
    parameter int                   VADDR_W   = 39,
    parameter int                   PADDR_W   = 56,
    parameter int                   L2_TAG_W  = 8,
    parameter logic [L2_TAG_W-1:0]  L2_TAG_ID = 8'h80
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_s0_valid,
    input  logic [VADDR_W-1:0]   i_s0_vaddr,
    output logic                 o_s0_ready,
    input  logic [PADDR_W-1:0]   i_s1_paddr,
    input  logic                 i_s1_tlb_miss,
    input  logic                 i_s1_kill,
    input  logic                 i_s2_kill,
    output logic                 o_s2_resp_valid,
    output logic [VADDR_W-1:0]   o_s2_resp_vaddr,
    output logic [LINE_W-1:0]    o_s2_resp_data,
    output logic                 o_s2_miss,
    output logic [VADDR_W-1:0]   o_s2_miss_vaddr,
    output logic                 o_l2_req_valid,
    input  logic                 i_l2_req_ready,
    output logic [PADDR_W-1:0]   o_l2_req_addr,
    output logic [L2_TAG_W-1:0]  o_l2_req_tag,
    input  logic                 i_l2_resp_valid,
    input  logic [L2_TAG_W-1:0]  i_l2_resp_tag,
    input  logic [LINE_W-1:0]    i_l2_resp_data,
`ifdef MSRH_ICACHE_INVALIDATE_EN
    input  logic                 i_inv_valid,
    output logic                 o_inv_done,
`endif
    output logic                 o_l2_resp_ready
);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = PADDR_W - IDX - OFF;
    localparam int WB  = $clog2(WAYS);

    // Index bits must lie inside the 4 KiB page offset so vaddr and paddr agree on them.
    generate
        if (OFF + IDX > 12) begin : g_vipt_alias_check
            $error("msrh_icache_assoc: OFF+IDX exceeds page offset, VIPT aliasing");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
`ifdef MSRH_ICACHE_INVALIDATE_EN
        , ST_INV = 2'd3
`endif
    } state_t;

    state_t               r_state;
    logic [TAG-1:0]       r_tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]    r_data_mem [WAYS][SETS];
    logic [TAG-1:0]       r_tag_rd   [WAYS];
    logic [LINE_W-1:0]    r_data_rd  [WAYS];
    logic [WAYS-1:0]      r_valid    [SETS];
    logic [WB-1:0]        r_rr       [SETS];

    logic                 r_s1_valid;
    logic [VADDR_W-1:0]   r_s1_vaddr;
    logic                 r_s2_hit;
    logic                 r_s2_miss;
    logic [VADDR_W-1:0]   r_s2_vaddr;
    logic [WAYS-1:0]      r_s2_way;
    logic [PADDR_W-OFF-1:0] r_miss_line;
    logic [IDX-1:0]       r_miss_idx;
    logic [WB-1:0]        r_miss_way;

    logic [IDX-1:0]       w_s0_idx;
    logic [IDX-1:0]       w_s1_idx;
    logic [TAG-1:0]       w_s1_tag;
    logic [WAYS-1:0]      w_s1_valid_bits;
    logic [WAYS-1:0]      w_hit_way;
    logic                 w_s1_hit;
    logic                 w_s1_miss;
    logic                 w_s0_fire;
    logic                 w_fill;
    logic [WB-1:0]        w_victim;
    logic [LINE_W-1:0]    w_s2_data;
    logic                 w_unused;

    assign w_s0_idx        = i_s0_vaddr[OFF +: IDX];
    assign w_s1_idx        = r_s1_vaddr[OFF +: IDX];
    assign w_s1_tag        = i_s1_paddr[PADDR_W-1:OFF+IDX];
    assign w_s1_valid_bits = r_valid[w_s1_idx];
    assign w_unused        = ^i_s1_paddr[OFF-1:0];

    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_way[w] = w_s1_valid_bits[w] & (r_tag_rd[w] == w_s1_tag);
        end
    end

    assign w_s1_hit  = r_s1_valid & (|w_hit_way) & ~i_s1_tlb_miss & ~i_s1_kill;
    assign w_s1_miss = r_s1_valid & ~(|w_hit_way) & ~i_s1_tlb_miss & ~i_s1_kill;
    assign w_fill    = (r_state == ST_WAIT) & i_l2_resp_valid & (i_l2_resp_tag == L2_TAG_ID);

    // Lowest invalid way wins; a full set falls back to its round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_s1_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_s1_valid_bits[w]) w_victim = WB'(w);
        end
    end

`ifdef MSRH_ICACHE_INVALIDATE_EN
    logic           r_inv_done;
    logic [IDX-1:0] r_inv_idx;
    assign o_s0_ready = (r_state == ST_IDLE) & ~w_s1_miss & ~i_inv_valid;
    assign o_inv_done = r_inv_done;
`else
    assign o_s0_ready = (r_state == ST_IDLE) & ~w_s1_miss;
`endif
    assign w_s0_fire = i_s0_valid & o_s0_ready;

    // Tag/data SRAMs: tags read in S0 for S1 compare, data read in S1 for S2 select.
    always_ff @(posedge i_clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_fill && (r_miss_way == WB'(w))) begin
                r_tag_mem[w][r_miss_idx]  <= r_miss_line[PADDR_W-OFF-1:IDX];
                r_data_mem[w][r_miss_idx] <= i_l2_resp_data;
            end
            r_tag_rd[w]  <= r_tag_mem[w][w_s0_idx];
            r_data_rd[w] <= r_data_mem[w][w_s1_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            if (w_fill) begin
                r_valid[r_miss_idx][r_miss_way] <= 1'b1;
                r_rr[r_miss_idx]                <= r_rr[r_miss_idx] + 1'b1;
            end
`ifdef MSRH_ICACHE_INVALIDATE_EN
            if (r_state == ST_INV) r_valid[r_inv_idx] <= '0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_s1_valid  <= 1'b0;
            r_s1_vaddr  <= '0;
            r_s2_hit    <= 1'b0;
            r_s2_miss   <= 1'b0;
            r_s2_vaddr  <= '0;
            r_s2_way    <= '0;
            r_miss_line <= '0;
            r_miss_idx  <= '0;
            r_miss_way  <= '0;
`ifdef MSRH_ICACHE_INVALIDATE_EN
            r_inv_done  <= 1'b0;
            r_inv_idx   <= '0;
`endif
        end else begin
            r_s1_valid <= w_s0_fire;
            if (w_s0_fire) r_s1_vaddr <= i_s0_vaddr;
            r_s2_hit   <= w_s1_hit;
            r_s2_miss  <= w_s1_miss;
            r_s2_vaddr <= r_s1_vaddr;
            r_s2_way   <= w_s1_hit ? w_hit_way : '0;
`ifdef MSRH_ICACHE_INVALIDATE_EN
            r_inv_done <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_s1_miss) begin
                        r_state     <= ST_REQ;
                        r_miss_line <= i_s1_paddr[PADDR_W-1:OFF];
                        r_miss_idx  <= w_s1_idx;
                        r_miss_way  <= w_victim;
                    end
`ifdef MSRH_ICACHE_INVALIDATE_EN
                    else if (i_inv_valid) begin
                        r_state   <= ST_INV;
                        r_inv_idx <= '0;
                    end
`endif
                end
                ST_REQ:  if (i_l2_req_ready) r_state <= ST_WAIT;
                ST_WAIT: if (w_fill) r_state <= ST_IDLE;
`ifdef MSRH_ICACHE_INVALIDATE_EN
                ST_INV: begin
                    r_inv_idx <= r_inv_idx + 1'b1;
                    if (r_inv_idx == IDX'(SETS - 1)) begin
                        r_state    <= ST_IDLE;
                        r_inv_done <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_s2_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_s2_way[w]) w_s2_data = w_s2_data | r_data_rd[w];
        end
    end

    assign o_s2_resp_valid = r_s2_hit & ~i_s2_kill;
    assign o_s2_miss       = r_s2_miss & ~i_s2_kill;
    assign o_s2_resp_vaddr = r_s2_vaddr;
    assign o_s2_miss_vaddr = r_s2_vaddr;
    assign o_s2_resp_data  = w_s2_data;
    assign o_l2_req_valid  = (r_state == ST_REQ);
    assign o_l2_req_addr   = {r_miss_line, {OFF{1'b0}}};
    assign o_l2_req_tag    = L2_TAG_ID;
    assign o_l2_resp_ready = 1'b1;

endmodule

// File: tb/tb_msrh_icache_assoc.sv
// Directed bench for msrh_icache_assoc: a vector table of fetches plus hand-written stall,
// reset-in-refill and (with MSRH_ICACHE_INVALIDATE_EN) invalidate sequences.
module tb_msrh_icache_assoc;
    localparam int WAYS = 4, SETS = 64, LINE_W = 128, VADDR_W = 39, PADDR_W = 56, L2_TAG_W = 8;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic                 i_s0_valid;
    logic [VADDR_W-1:0]   i_s0_vaddr;
    logic                 o_s0_ready;
    logic [PADDR_W-1:0]   i_s1_paddr;
    logic                 i_s1_tlb_miss, i_s1_kill, i_s2_kill;
    logic                 o_s2_resp_valid, o_s2_miss;
    logic [VADDR_W-1:0]   o_s2_resp_vaddr, o_s2_miss_vaddr;
    logic [LINE_W-1:0]    o_s2_resp_data;
    logic                 o_l2_req_valid, i_l2_req_ready;
    logic [PADDR_W-1:0]   o_l2_req_addr;
    logic [L2_TAG_W-1:0]  o_l2_req_tag;
    logic                 i_l2_resp_valid;
    logic [L2_TAG_W-1:0]  i_l2_resp_tag;
    logic [LINE_W-1:0]    i_l2_resp_data;
    logic                 o_l2_resp_ready;
`ifdef MSRH_ICACHE_INVALIDATE_EN
    logic                 i_inv_valid;
    logic                 o_inv_done;
`endif

    always #5 clk = ~clk;

    msrh_icache_assoc dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_s0_valid(i_s0_valid), .i_s0_vaddr(i_s0_vaddr), .o_s0_ready(o_s0_ready),
        .i_s1_paddr(i_s1_paddr), .i_s1_tlb_miss(i_s1_tlb_miss), .i_s1_kill(i_s1_kill),
        .i_s2_kill(i_s2_kill),
        .o_s2_resp_valid(o_s2_resp_valid), .o_s2_resp_vaddr(o_s2_resp_vaddr),
        .o_s2_resp_data(o_s2_resp_data), .o_s2_miss(o_s2_miss), .o_s2_miss_vaddr(o_s2_miss_vaddr),
        .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
        .o_l2_req_addr(o_l2_req_addr), .o_l2_req_tag(o_l2_req_tag),
        .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp_tag(i_l2_resp_tag),
        .i_l2_resp_data(i_l2_resp_data),
`ifdef MSRH_ICACHE_INVALIDATE_EN
        .i_inv_valid(i_inv_valid), .o_inv_done(o_inv_done),
`endif
        .o_l2_resp_ready(o_l2_resp_ready)
    );

    typedef struct packed {
        logic [VADDR_W-1:0] vaddr;
        logic [PADDR_W-1:0] paddr;
        logic               tlb, k1, k2;
        logic               hit;   // o_s2_resp_valid expected
        logic               miss;  // o_s2_miss expected
        logic               req;   // refill launched
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Refill payload is a function of the line address, so every line carries distinct data.
    function automatic logic [LINE_W-1:0] line_data(input logic [PADDR_W-1:0] pa);
        logic [31:0] a;
        a = pa[31:0] & 32'hFFFF_FFF0;
        return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, a ^ 32'h3333_3333, ~a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [VADDR_W-1:0] va, input logic [PADDR_W-1:0] pa,
                       input logic tlb, input logic k1, input logic k2,
                       input logic hit, input logic miss, input logic req);
        vec_t v;
        v.vaddr = va; v.paddr = pa; v.tlb = tlb; v.k1 = k1; v.k2 = k2;
        v.hit = hit; v.miss = miss; v.req = req;
        tbl.push_back(v);
    endtask

    task automatic serve(input logic [PADDR_W-1:0] pa, input logic [L2_TAG_W-1:0] tag);
        i_l2_req_ready = 1'b1;
        tick();
        i_l2_req_ready  = 1'b0;
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = tag;
        i_l2_resp_data  = line_data(pa);
        tick();
        i_l2_resp_valid = 1'b0;
    endtask

    // One fetch through S0/S1/S2; returns in the cycle after S2.
    task automatic fetch(input vec_t v, input string id, input bit auto_serve);
        int guard;
        i_s0_valid = 1'b1;
        i_s0_vaddr = v.vaddr;
        guard = 0;
        @(negedge clk);
        while (!o_s0_ready && guard < 50) begin
            tick();
            guard++;
            @(negedge clk);
        end
        check({id, "_s0_ready_wait"}, o_s0_ready, 1'b1);
        tick();
        i_s0_valid    = 1'b0;
        i_s1_paddr    = v.paddr;
        i_s1_tlb_miss = v.tlb;
        i_s1_kill     = v.k1;
        @(negedge clk);
        check({id, "_s1_s0_ready"}, o_s0_ready, !v.req);
        tick();
        i_s1_tlb_miss = 1'b0;
        i_s1_kill     = 1'b0;
        i_s2_kill     = v.k2;
        @(negedge clk);
        check({id, "_resp_valid"}, o_s2_resp_valid, v.hit);
        check({id, "_miss"}, o_s2_miss, v.miss);
        check({id, "_l2_req_valid"}, o_l2_req_valid, v.req);
        if (v.hit) begin
            check({id, "_data"}, o_s2_resp_data, line_data(v.paddr));
            check({id, "_resp_vaddr"}, o_s2_resp_vaddr, v.vaddr);
        end
        if (v.miss) check({id, "_miss_vaddr"}, o_s2_miss_vaddr, v.vaddr);
        if (v.req) begin
            check({id, "_req_addr"}, o_l2_req_addr, {v.paddr[PADDR_W-1:4], 4'h0});
            check({id, "_req_tag"}, o_l2_req_tag, 8'h80);
        end
        tick();
        i_s2_kill = 1'b0;
        if (auto_serve && o_l2_req_valid) serve(v.paddr, 8'h80);
    endtask

    task automatic reset_dut();
        i_reset = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   cnt;
        i_s0_valid = 0; i_s0_vaddr = '0; i_s1_paddr = '0; i_s1_tlb_miss = 0; i_s1_kill = 0;
        i_s2_kill = 0; i_l2_req_ready = 0; i_l2_resp_valid = 0; i_l2_resp_tag = '0;
        i_l2_resp_data = '0;
`ifdef MSRH_ICACHE_INVALIDATE_EN
        i_inv_valid = 0;
`endif
        #1;
        reset_dut();
        @(negedge clk);
        check("rst_resp_valid", o_s2_resp_valid, 1'b0);
        check("rst_miss", o_s2_miss, 1'b0);
        check("rst_l2_req_valid", o_l2_req_valid, 1'b0);
        check("rst_l2_req_addr", o_l2_req_addr, '0);
        check("rst_resp_data", o_s2_resp_data, '0);
        check("rst_l2_resp_ready", o_l2_resp_ready, 1'b1);
        tick();

        //      vaddr       paddr            tlb k1 k2 hit miss req
        add(39'h1000, 56'h8000_1000, 0, 0, 0, 0, 1, 1);  // cold miss
        add(39'h1000, 56'h8000_1000, 0, 0, 0, 1, 0, 0);
        add(39'h2000, 56'h8000_2000, 0, 0, 0, 0, 1, 1);
        add(39'h3000, 56'h8000_3000, 0, 0, 0, 0, 1, 1);
        add(39'h4000, 56'h8000_4000, 0, 0, 0, 0, 1, 1);  // set 0 now full
        add(39'h1000, 56'h8000_1000, 0, 0, 0, 1, 0, 0);
        add(39'h2000, 56'h8000_2000, 0, 0, 0, 1, 0, 0);
        add(39'h3000, 56'h8000_3000, 0, 0, 0, 1, 0, 0);
        add(39'h4000, 56'h8000_4000, 0, 0, 0, 1, 0, 0);
        add(39'h5000, 56'h8000_5000, 0, 0, 0, 0, 1, 1);  // evicts way 0 (0x1000)
        add(39'h2000, 56'h8000_2000, 0, 0, 0, 1, 0, 0);
        add(39'h3000, 56'h8000_3000, 0, 0, 0, 1, 0, 0);
        add(39'h4000, 56'h8000_4000, 0, 0, 0, 1, 0, 0);
        add(39'h5000, 56'h8000_5000, 0, 0, 0, 1, 0, 0);
        add(39'h6000, 56'h8000_6000, 0, 0, 0, 0, 1, 1);  // evicts way 1 (0x2000)
        add(39'h3000, 56'h8000_3000, 0, 0, 0, 1, 0, 0);
        add(39'h4000, 56'h8000_4000, 0, 0, 0, 1, 0, 0);
        add(39'h5000, 56'h8000_5000, 0, 0, 0, 1, 0, 0);
        add(39'h6000, 56'h8000_6000, 0, 0, 0, 1, 0, 0);
        add(39'h2000, 56'h8000_2000, 0, 0, 0, 0, 1, 1);  // evicts way 2 (0x3000)
        add(39'h2000, 56'h8000_2000, 0, 0, 0, 1, 0, 0);
        add(39'h4000, 56'h8000_4000, 0, 0, 0, 1, 0, 0);
        add(39'h3000, 56'h8000_3000, 0, 0, 0, 0, 1, 1);  // evicts way 3 (0x4000)
        add(39'h4000, 56'h8000_4000, 0, 0, 0, 0, 1, 1);  // evicts way 0 (0x5000)
        add(39'h6000, 56'h8000_6000, 0, 0, 0, 1, 0, 0);
        add(39'h1040, 56'h9000_0048, 1, 0, 0, 0, 0, 0);  // TLB miss
        add(39'h1040, 56'h9000_0048, 0, 1, 0, 0, 0, 0);  // S1 kill
        add(39'h1040, 56'h9000_0048, 0, 0, 0, 0, 1, 1);  // unaligned paddr miss
        add(39'h1040, 56'h9000_0048, 0, 0, 1, 0, 0, 0);  // S2 kill on hit
        add(39'h1040, 56'h9000_0048, 0, 0, 0, 1, 0, 0);
        add(39'h2080, 56'hA000_2080, 0, 0, 1, 0, 0, 1);  // S2 kill after launch
        add(39'h2080, 56'hA000_2080, 0, 0, 0, 1, 0, 0);  // line still installed

        for (int i = 0; i < tbl.size(); i++) fetch(tbl[i], $sformatf("v%0d", i), 1'b1);

        // L2 stalls for 5 cycles, then a foreign-tag response is ignored.
        v = '0; v.vaddr = 39'h30C0; v.paddr = 56'hB000_30C0; v.miss = 1; v.req = 1;
        fetch(v, "stall", 1'b0);
        for (int i = 0; i < 5; i++) begin
            i_s0_valid = 1'b1;
            i_s0_vaddr = 39'h1000;
            @(negedge clk);
            check($sformatf("stall%0d_req_valid", i), o_l2_req_valid, 1'b1);
            check($sformatf("stall%0d_req_addr", i), o_l2_req_addr, 56'hB000_30C0);
            check($sformatf("stall%0d_s0_ready", i), o_s0_ready, 1'b0);
            tick();
        end
        i_s0_valid = 1'b0;
        i_l2_req_ready = 1'b1;
        tick();
        i_l2_req_ready  = 1'b0;
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = 8'h01;
        i_l2_resp_data  = {4{32'hDEAD_BEEF}};
        tick();
        i_l2_resp_valid = 1'b0;
        @(negedge clk);
        check("badtag_s0_ready", o_s0_ready, 1'b0);
        check("badtag_req_valid", o_l2_req_valid, 1'b0);
        tick();
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = 8'h80;
        i_l2_resp_data  = line_data(56'hB000_30C0);
        tick();
        i_l2_resp_valid = 1'b0;
        v.miss = 0; v.req = 0; v.hit = 1;
        fetch(v, "stall_hit", 1'b1);

        // Reset while waiting for the response; the late response must not install.
        v = '0; v.vaddr = 39'h4100; v.paddr = 56'hC000_4100; v.miss = 1; v.req = 1;
        fetch(v, "rstw", 1'b0);
        i_l2_req_ready = 1'b1;
        tick();
        i_l2_req_ready = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        check("rstw_req_valid", o_l2_req_valid, 1'b0);
        check("rstw_s0_ready", o_s0_ready, 1'b1);
        tick();
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = 8'h80;
        i_l2_resp_data  = line_data(56'hC000_4100);
        tick();
        i_l2_resp_valid = 1'b0;
        @(negedge clk);
        check("rstw_late_s0_ready", o_s0_ready, 1'b1);
        tick();
        fetch(v, "rstw_refetch", 1'b1);
        v.miss = 0; v.req = 0; v.hit = 1;
        fetch(v, "rstw_hit", 1'b1);

`ifdef MSRH_ICACHE_INVALIDATE_EN
        for (int i = 0; i < 3; i++) begin
            v = '0; v.vaddr = 39'h140 + 39'(i * 16); v.paddr = 56'hD000_0140 + 56'(i * 16);
            v.miss = 1; v.req = 1;
            fetch(v, $sformatf("inv_fill%0d", i), 1'b1);
            v.miss = 0; v.req = 0; v.hit = 1;
            fetch(v, $sformatf("inv_pre%0d", i), 1'b1);
        end
        i_inv_valid = 1'b1;
        tick();
        i_inv_valid = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (!o_inv_done && cnt < SETS + 20) begin
            check($sformatf("inv_s0_ready_c%0d", cnt), o_s0_ready, 1'b0);
            tick();
            cnt++;
            @(negedge clk);
        end
        check("inv_done_seen", o_inv_done, 1'b1);
        check("inv_done_cycle", 32'(cnt), 32'(SETS + 1));
        tick();
        @(negedge clk);
        check("inv_done_pulse", o_inv_done, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            v = '0; v.vaddr = 39'h140 + 39'(i * 16); v.paddr = 56'hD000_0140 + 56'(i * 16);
            v.miss = 1; v.req = 1;
            fetch(v, $sformatf("inv_post%0d", i), 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/msrh_icache_assoc.md
# msrh_icache_assoc

Parametrised N-way set-associative instruction cache for the msrh frontend. It sits between the fetch unit (S0 virtual request, S1 physical address from the ITLB) and the L2 request/response channel. Unlike the single-line generation, it:
- writes only one victim way per fill, chosen per set (invalid-first, else round-robin);
- supports per-stage kill;
- holds valid bits in resettable flops.

Data returns two cycles after S0 acceptance.

## Interface
Parameters:
- WAYS, 4, ways per set (power of two, ≥2)
- SETS, 64, sets (power of two)
- LINE_W, 128, line width in bits; one L2 beat fills one line
- VADDR_W, 39, virtual address width
- PADDR_W, 56, physical address width
- L2_TAG_W, 8, L2 command tag width
- L2_TAG_ID, 8'h80, fixed L2 tag used for every I$ refill

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_s0_valid  in  1  fetch request
- i_s0_vaddr  in  VADDR_W  fetch virtual address
- o_s0_ready  out  1  request accepted this cycle when valid&ready
- i_s1_paddr  in  PADDR_W  translated address of S1 request
- i_s1_tlb_miss  in  1  S1 translation failed
- i_s1_kill  in  1  drop S1 request
- i_s2_kill  in  1  drop S2 request
- o_s2_resp_valid  out  1  hit data valid
- o_s2_resp_vaddr  out  VADDR_W  vaddr of returned line
- o_s2_resp_data  out  LINE_W  line data
- o_s2_miss  out  1  S2 request missed (refill launched)
- o_s2_miss_vaddr  out  VADDR_W  vaddr of missed request
- o_l2_req_valid  out  1  refill request
- i_l2_req_ready  in  1  L2 accepts request
- o_l2_req_addr  out  PADDR_W  line-aligned physical address
- o_l2_req_tag  out  L2_TAG_W  always L2_TAG_ID
- i_l2_resp_valid  in  1  L2 response
- i_l2_resp_tag  in  L2_TAG_W  response tag
- i_l2_resp_data  in  LINE_W  refill data
- o_l2_resp_ready  out  1  constant 1

## Operation
Address fields:
- OFF = log2(LINE_W/8); IDX = log2(SETS); TAG = PADDR_W-IDX-OFF.
- Index taken from vaddr[OFF+:IDX]; tag from paddr[PADDR_W-1:OFF+IDX].
- Elaboration error if OFF+IDX > 12 (VIPT aliasing).

Arrays:
- Tag and data are synchronous-read SRAM, one per way.
- Valid bits are WAYS×SETS flops, cleared by reset.

Pipeline:
- S0: index reads all ways.
- S1: hit[w] = valid[w] & tag match; hit = |hit & !tlb_miss & !s1_kill.
- S2: one-hot way-select of registered data.
- Multi-way hit cannot occur; no priority is required.

Miss FSM:
- IDLE → REQ on S1 valid & !hit & !tlb_miss & !s1_kill. Capture paddr (line-aligned), vaddr, and victim way.
- REQ: hold o_l2_req_valid until i_l2_req_ready, then → WAIT. Payload stable while valid.
- WAIT: on i_l2_resp_valid & tag==L2_TAG_ID, write data/tag into the victim way, set its valid, advance the set's round-robin pointer, → IDLE. Non-matching tags are ignored.
- o_s0_ready = (state==IDLE) & !(S1 missing this cycle).

Victim selection: lowest-index invalid way; otherwise per-set round-robin pointer (log2(WAYS) bits, wraps WAYS-1→0).

Other rules:
- TLB miss: neither hit nor refill. o_s2_miss=0, o_s2_resp_valid=0.
- Kill: i_s1_kill suppresses both hit and refill launch. i_s2_kill clears o_s2_resp_valid/o_s2_miss in the same cycle (combinational mask). Kill after refill launch does not abort the refill; the line is still installed.

## Timing
- Hit latency: S0 accept at cycle N → o_s2_resp_valid at N+2.
- o_s2_miss at N+2 for a miss at S1 in N+1, single cycle, concurrent with o_l2_req_valid rising.
- Fill write happens in the response cycle; the first new S0 is accepted the following cycle and hits at +2.
- Reset values: all outputs 0, o_l2_resp_ready 1, state IDLE, all valid bits 0, all RR pointers 0. Reset mid-refill returns to IDLE; a late L2 response is then ignored (state≠WAIT).

## Configuration
- MSRH_ICACHE_INVALIDATE_EN defined:
  - Adds ports i_inv_valid (in 1) and o_inv_done (out 1).
  - i_inv_valid in IDLE enters state INV, which clears one set's valid bits per cycle, index 0..SETS-1.
  - o_inv_done pulses one cycle after the last set; then → IDLE.
  - o_s0_ready=0 throughout INV. i_inv_valid in other states is held off until IDLE.
- Undefined: no such ports; INV state absent. Valid bits clear only on reset.

## Test plan
- Cold miss: reset, fetch vaddr 0x1000/paddr 0x8000_1000 → o_s2_miss=1 at +2; L2 req addr 0x8000_1000, tag 8'h80; respond → refetch hits at +2 with matching data.
- Fill all ways of set 0 with 4 distinct tags, then a fifth → evicts way 0; sixth → evicts way 1; the four resident lines hit.
- L2 ready held low 5 cycles → o_l2_req_valid/addr stable, o_s0_ready=0 throughout; resp with tag 8'h01 ignored.
- TLB miss and s1_kill on a missing address → no L2 req, o_s2_miss=0; s2_kill on a hit → o_s2_resp_valid=0.
- Reset asserted in WAIT, then L2 response → no line installed; refetch misses.
- (INVALIDATE_EN) fill 3 lines, pulse i_inv_valid → o_inv_done after SETS cycles; all three refetches miss.
